// File: rtl/special_case_fmac_if.sv
// Operand/result bundle for the FMAC special-case stage.
// Upstream side: Valid_SI/Ready_SO plus unpacked operand fields and class flags.
// Downstream side: Valid_SO/Ready_SI plus registered fields, effective signs and early-out result.
interface special_case_fmac_if #(
  parameter int C_OP   = 32,
  parameter int C_EXP  = 8,
  parameter int C_MANT = 23
);
  // upstream
  logic              Valid_SI;
  logic              Ready_SO;
  logic [1:0]        Op_SI;
  logic              Sign_a_DI, Sign_b_DI, Sign_c_DI;
  logic [C_EXP-1:0]  Exp_a_DI, Exp_b_DI, Exp_c_DI;
  logic [C_MANT:0]   Mant_a_DI, Mant_b_DI, Mant_c_DI;
  logic              Inf_a_SI, Inf_b_SI, Inf_c_SI;
  logic              NaN_a_SI, NaN_b_SI, NaN_c_SI;
  logic              DeN_a_SI, DeN_b_SI, DeN_c_SI;
  logic              Zero_a_SI, Zero_b_SI;
  // downstream
  logic              Valid_SO;
  logic              Ready_SI;
  logic [1:0]        Op_SO;
  logic              Sign_a_DO, Sign_b_DO, Sign_c_DO;
  logic [C_EXP-1:0]  Exp_a_DO, Exp_b_DO, Exp_c_DO;
  logic [C_MANT:0]   Mant_a_DO, Mant_b_DO, Mant_c_DO;
  logic              DeN_a_SO, DeN_b_SO, DeN_c_SO;
  logic              Zero_a_SO, Zero_b_SO;
  logic              Sign_prod_DO;
  logic              Sign_c_eff_DO;
  logic              Special_SO;
  logic [C_OP-1:0]   Special_result_DO;
  logic              NV_SO;

  // stage view
  modport slave (
    input  Valid_SI, Op_SI, Sign_a_DI, Sign_b_DI, Sign_c_DI,
           Exp_a_DI, Exp_b_DI, Exp_c_DI, Mant_a_DI, Mant_b_DI, Mant_c_DI,
           Inf_a_SI, Inf_b_SI, Inf_c_SI, NaN_a_SI, NaN_b_SI, NaN_c_SI,
           DeN_a_SI, DeN_b_SI, DeN_c_SI, Zero_a_SI, Zero_b_SI, Ready_SI,
    output Ready_SO, Valid_SO, Op_SO, Sign_a_DO, Sign_b_DO, Sign_c_DO,
           Exp_a_DO, Exp_b_DO, Exp_c_DO, Mant_a_DO, Mant_b_DO, Mant_c_DO,
           DeN_a_SO, DeN_b_SO, DeN_c_SO, Zero_a_SO, Zero_b_SO,
           Sign_prod_DO, Sign_c_eff_DO, Special_SO, Special_result_DO, NV_SO
  );

  // producer/consumer view
  modport master (
    output Valid_SI, Op_SI, Sign_a_DI, Sign_b_DI, Sign_c_DI,
           Exp_a_DI, Exp_b_DI, Exp_c_DI, Mant_a_DI, Mant_b_DI, Mant_c_DI,
           Inf_a_SI, Inf_b_SI, Inf_c_SI, NaN_a_SI, NaN_b_SI, NaN_c_SI,
           DeN_a_SI, DeN_b_SI, DeN_c_SI, Zero_a_SI, Zero_b_SI, Ready_SI,
    input  Ready_SO, Valid_SO, Op_SO, Sign_a_DO, Sign_b_DO, Sign_c_DO,
           Exp_a_DO, Exp_b_DO, Exp_c_DO, Mant_a_DO, Mant_b_DO, Mant_c_DO,
           DeN_a_SO, DeN_b_SO, DeN_c_SO, Zero_a_SO, Zero_b_SO,
           Sign_prod_DO, Sign_c_eff_DO, Special_SO, Special_result_DO, NV_SO
  );
endinterface

// File: rtl/special_case_fmac.sv
// FMAC special-case stage: resolves NaN/Inf/invalid into an early-out result and
// registers all operand fields toward the datapath. 1-cycle latency; 2-entry skid
// (output reg + skid reg), Ready_SO = ~skid_valid so no Ready_SI->Ready_SO path.
// Ports: Clk_CI, Rst_RI (sync, active high), io (special_case_fmac_if.slave).
// Optional: FMAC_DEN_FTZ_EN flushes denormal operands to zero (fields, flags, rule 2).
module special_case_fmac #(
  parameter int C_OP   = 32,
  parameter int C_EXP  = 8,
  parameter int C_MANT = 23
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  special_case_fmac_if.slave   io
);

  typedef struct packed {
    logic [1:0]        op;
    logic              sign_a, sign_b, sign_c;
    logic [C_EXP-1:0]  exp_a, exp_b, exp_c;
    logic [C_MANT:0]   mant_a, mant_b, mant_c;
    logic              den_a, den_b, den_c;
    logic              zero_a, zero_b;
    logic              sign_prod;
    logic              sign_c_eff;
    logic              special;
    logic [C_OP-1:0]   result;
    logic              nv;
  } stage_t;

  localparam logic [C_OP-1:0] QNAN = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};

  stage_t in_d;
  stage_t out_q, skid_q;
  logic   out_vld, skid_vld;
  logic   accept, drain;
  logic   any_nan, any_snan;

  // Operand capture plus special-case resolution, all from the current inputs.
  always_comb begin
    in_d        = '0;
    in_d.op     = io.Op_SI;
    in_d.sign_a = io.Sign_a_DI;
    in_d.sign_b = io.Sign_b_DI;
    in_d.sign_c = io.Sign_c_DI;
    in_d.exp_a  = io.Exp_a_DI;
    in_d.exp_b  = io.Exp_b_DI;
    in_d.exp_c  = io.Exp_c_DI;
    in_d.mant_a = io.Mant_a_DI;
    in_d.mant_b = io.Mant_b_DI;
    in_d.mant_c = io.Mant_c_DI;
    in_d.den_a  = io.DeN_a_SI;
    in_d.den_b  = io.DeN_b_SI;
    in_d.den_c  = io.DeN_c_SI;
    in_d.zero_a = io.Zero_a_SI;
    in_d.zero_b = io.Zero_b_SI;
`ifdef FMAC_DEN_FTZ_EN
    // Denormals become true zeros; the zero flags of a/b then feed rule 2 below.
    if (io.DeN_a_SI) begin
      in_d.exp_a  = '0;
      in_d.mant_a = '0;
      in_d.den_a  = 1'b0;
      in_d.zero_a = 1'b1;
    end
    if (io.DeN_b_SI) begin
      in_d.exp_b  = '0;
      in_d.mant_b = '0;
      in_d.den_b  = 1'b0;
      in_d.zero_b = 1'b1;
    end
    if (io.DeN_c_SI) begin
      in_d.exp_c  = '0;
      in_d.mant_c = '0;
      in_d.den_c  = 1'b0;
    end
`endif
    in_d.sign_prod  = io.Sign_a_DI ^ io.Sign_b_DI ^ io.Op_SI[1];
    in_d.sign_c_eff = io.Sign_c_DI ^ io.Op_SI[0];

    any_nan  = io.NaN_a_SI | io.NaN_b_SI | io.NaN_c_SI;
    // Quiet bit is the MSB of the stored fraction; clear means signalling.
    any_snan = (io.NaN_a_SI & ~io.Mant_a_DI[C_MANT-1]) |
               (io.NaN_b_SI & ~io.Mant_b_DI[C_MANT-1]) |
               (io.NaN_c_SI & ~io.Mant_c_DI[C_MANT-1]);

    if (any_nan) begin
      in_d.special = 1'b1;
      in_d.result  = QNAN;
      in_d.nv      = any_snan;
    end else if ((io.Inf_a_SI & in_d.zero_b) | (in_d.zero_a & io.Inf_b_SI)) begin
      // Inf * 0
      in_d.special = 1'b1;
      in_d.result  = QNAN;
      in_d.nv      = 1'b1;
    end else if ((io.Inf_a_SI | io.Inf_b_SI) & io.Inf_c_SI &
                 (in_d.sign_prod != in_d.sign_c_eff)) begin
      // Inf - Inf after sign resolution
      in_d.special = 1'b1;
      in_d.result  = QNAN;
      in_d.nv      = 1'b1;
    end else if (io.Inf_a_SI | io.Inf_b_SI) begin
      in_d.special = 1'b1;
      in_d.result  = {in_d.sign_prod, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
    end else if (io.Inf_c_SI) begin
      in_d.special = 1'b1;
      in_d.result  = {in_d.sign_c_eff, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
    end
  end

  assign accept = io.Valid_SI & ~skid_vld;
  assign drain  = ~out_vld | io.Ready_SI;

  // Skid entry only fills while the output is stalled, and always drains into
  // the output register before a new accept, so order is preserved.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (drain) begin
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_q   <= in_d;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= in_d;
      skid_vld <= 1'b1;
    end
  end

  assign io.Ready_SO          = ~skid_vld;
  assign io.Valid_SO          = out_vld;
  assign io.Op_SO             = out_q.op;
  assign io.Sign_a_DO         = out_q.sign_a;
  assign io.Sign_b_DO         = out_q.sign_b;
  assign io.Sign_c_DO         = out_q.sign_c;
  assign io.Exp_a_DO          = out_q.exp_a;
  assign io.Exp_b_DO          = out_q.exp_b;
  assign io.Exp_c_DO          = out_q.exp_c;
  assign io.Mant_a_DO         = out_q.mant_a;
  assign io.Mant_b_DO         = out_q.mant_b;
  assign io.Mant_c_DO         = out_q.mant_c;
  assign io.DeN_a_SO          = out_q.den_a;
  assign io.DeN_b_SO          = out_q.den_b;
  assign io.DeN_c_SO          = out_q.den_c;
  assign io.Zero_a_SO         = out_q.zero_a;
  assign io.Zero_b_SO         = out_q.zero_b;
  assign io.Sign_prod_DO      = out_q.sign_prod;
  assign io.Sign_c_eff_DO     = out_q.sign_c_eff;
  assign io.Special_SO        = out_q.special;
  assign io.Special_result_DO = out_q.result;
  assign io.NV_SO             = out_q.nv;

endmodule

// File: tb/tb_special_case_fmac.sv
// Self-checking bench for special_case_fmac: directed IEEE-754 vectors with literal
// expectations, plus a float-level reference model and occupancy scoreboard checked
// every cycle. Honours FMAC_DEN_FTZ_EN for the denormal vector.
module tb_special_case_fmac;

  typedef struct packed {
    logic [1:0]  op;
    logic        sign_a, sign_b, sign_c;
    logic [7:0]  exp_a, exp_b, exp_c;
    logic [23:0] mant_a, mant_b, mant_c;
    logic        den_a, den_b, den_c;
    logic        zero_a, zero_b;
    logic        sign_prod, sign_c_eff, special;
    logic [31:0] result;
    logic        nv;
  } exp_t;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [23:0] m;
    logic        inf, nan, den, zero;
  } cls_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  special_case_fmac_if #(.C_OP(32), .C_EXP(8), .C_MANT(23)) bus ();

  special_case_fmac #(.C_OP(32), .C_EXP(8), .C_MANT(23)) dut (
    .Clk_CI (clk),
    .Rst_RI (rst),
    .io     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_out  = 0;
  exp_t q[$];
  logic [1:0]  cur_op;
  logic [31:0] cur_a, cur_b, cur_c;

  localparam logic [31:0] P_INF = 32'h7F800000, N_INF = 32'hFF800000, ONE = 32'h3F800000;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // What upstream disassembly would hand us for a raw single-precision value.
  function automatic cls_t classify(input logic [31:0] x);
    cls_t c;
    c.s    = x[31];
    c.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    c.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    c.den  = (x[30:23] == 8'h00) && (x[22:0] != 0);
    c.zero = (x[30:23] == 8'h00) && (x[22:0] == 0);
    c.e    = c.den ? 8'd1 : x[30:23];
    c.m    = {x[30:23] != 8'h00, x[22:0]};
    return c;
  endfunction

  // Float-level reference: IEEE special-case rules applied to the raw operands.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, b, c);
    cls_t ca = classify(a);
    cls_t cb = classify(b);
    cls_t cc = classify(c);
    exp_t e = '0;
    logic sp, ce, prod_inf;
    e.op = op;
    e.sign_a = ca.s; e.exp_a = ca.e; e.mant_a = ca.m; e.den_a = ca.den; e.zero_a = ca.zero;
    e.sign_b = cb.s; e.exp_b = cb.e; e.mant_b = cb.m; e.den_b = cb.den; e.zero_b = cb.zero;
    e.sign_c = cc.s; e.exp_c = cc.e; e.mant_c = cc.m; e.den_c = cc.den;
`ifdef FMAC_DEN_FTZ_EN
    if (ca.den) begin e.exp_a = 0; e.mant_a = 0; e.den_a = 0; e.zero_a = 1; end
    if (cb.den) begin e.exp_b = 0; e.mant_b = 0; e.den_b = 0; e.zero_b = 1; end
    if (cc.den) begin e.exp_c = 0; e.mant_c = 0; e.den_c = 0; end
`endif
    sp = (op == 2'b10 || op == 2'b11) ? ~(a[31] ^ b[31]) : (a[31] ^ b[31]);
    ce = (op == 2'b01 || op == 2'b11) ? ~c[31] : c[31];
    e.sign_prod = sp; e.sign_c_eff = ce;
    prod_inf = ca.inf || cb.inf;
    if (ca.nan || cb.nan || cc.nan) begin
      e.special = 1; e.result = QNAN;
      e.nv = (ca.nan && !a[22]) || (cb.nan && !b[22]) || (cc.nan && !c[22]);
    end else if ((ca.inf && e.zero_b) || (e.zero_a && cb.inf)) begin
      e.special = 1; e.result = QNAN; e.nv = 1;
    end else if (prod_inf && cc.inf && sp != ce) begin
      e.special = 1; e.result = QNAN; e.nv = 1;
    end else if (prod_inf) begin
      e.special = 1; e.result = {sp, 31'h7F800000};
    end else if (cc.inf) begin
      e.special = 1; e.result = {ce, 31'h7F800000};
    end
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t d;
    d.op = bus.Op_SO;
    d.sign_a = bus.Sign_a_DO; d.sign_b = bus.Sign_b_DO; d.sign_c = bus.Sign_c_DO;
    d.exp_a = bus.Exp_a_DO; d.exp_b = bus.Exp_b_DO; d.exp_c = bus.Exp_c_DO;
    d.mant_a = bus.Mant_a_DO; d.mant_b = bus.Mant_b_DO; d.mant_c = bus.Mant_c_DO;
    d.den_a = bus.DeN_a_SO; d.den_b = bus.DeN_b_SO; d.den_c = bus.DeN_c_SO;
    d.zero_a = bus.Zero_a_SO; d.zero_b = bus.Zero_b_SO;
    d.sign_prod = bus.Sign_prod_DO; d.sign_c_eff = bus.Sign_c_eff_DO;
    d.special = bus.Special_SO; d.result = bus.Special_result_DO; d.nv = bus.NV_SO;
    return d;
  endfunction

  task automatic drive(input logic [1:0] op, input logic [31:0] a, b, c);
    cls_t ca = classify(a);
    cls_t cb = classify(b);
    cls_t cc = classify(c);
    cur_op = op; cur_a = a; cur_b = b; cur_c = c;
    bus.Op_SI = op;
    bus.Sign_a_DI = ca.s; bus.Exp_a_DI = ca.e; bus.Mant_a_DI = ca.m;
    bus.Sign_b_DI = cb.s; bus.Exp_b_DI = cb.e; bus.Mant_b_DI = cb.m;
    bus.Sign_c_DI = cc.s; bus.Exp_c_DI = cc.e; bus.Mant_c_DI = cc.m;
    bus.Inf_a_SI = ca.inf; bus.Inf_b_SI = cb.inf; bus.Inf_c_SI = cc.inf;
    bus.NaN_a_SI = ca.nan; bus.NaN_b_SI = cb.nan; bus.NaN_c_SI = cc.nan;
    bus.DeN_a_SI = ca.den; bus.DeN_b_SI = cb.den; bus.DeN_c_SI = cc.den;
    bus.Zero_a_SI = ca.zero; bus.Zero_b_SI = cb.zero;
  endtask

  // Single transaction with Ready_SI high; result must appear one cycle after accept.
  task automatic send_chk(input string name, input logic [1:0] op, input logic [31:0] a, b, c,
                          input logic special, input logic [31:0] res, input logic nv,
                          input logic [23:0] mant_b);
    int t = 0;
    @(posedge clk); #1;
    bus.Ready_SI = 1'b1;
    drive(op, a, b, c);
    bus.Valid_SI = 1'b1;
    while (!bus.Ready_SO && t < 20) begin @(posedge clk); #1; t++; end
    check({name, "_ready_wait"}, 192'(bus.Ready_SO), 192'(1'b1));
    @(posedge clk); #1;
    bus.Valid_SI = 1'b0;
    @(negedge clk);
    check({name, "_valid"},   192'(bus.Valid_SO), 192'(1'b1));
    check({name, "_special"}, 192'(bus.Special_SO), 192'(special));
    check({name, "_result"},  192'(bus.Special_result_DO), 192'(res));
    check({name, "_nv"},      192'(bus.NV_SO), 192'(nv));
    check({name, "_mant_b"},  192'(bus.Mant_b_DO), 192'(mant_b));
  endtask

  // Scoreboard: stage occupancy predicts Valid_SO/Ready_SO; head entry predicts data.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("valid_vs_occupancy", 192'(bus.Valid_SO), 192'(q.size() > 0));
      check("ready_vs_occupancy", 192'(bus.Ready_SO), 192'(q.size() < 2));
      if (bus.Valid_SO && q.size() > 0) check("out_data", 192'(dut_out()), 192'(q[0]));
      if (rst) begin
        q.delete();
      end else begin
        if (bus.Valid_SO && bus.Ready_SI && q.size() > 0) begin
          void'(q.pop_front());
          n_out++;
        end
        if (bus.Valid_SI && bus.Ready_SO) q.push_back(model(cur_op, cur_a, cur_b, cur_c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t pin;
    int   base;
    bus.Valid_SI = 1'b0;
    bus.Ready_SI = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 32'h0);

    // Hand-computed pins on the reference model itself.
    pin = model(2'b00, P_INF, 32'h0, 32'h0);
    check("model_pin_inf_x_zero", 192'({pin.special, pin.result, pin.nv}), 192'({1'b1, QNAN, 1'b1}));
    pin = model(2'b11, ONE, ONE, N_INF);
    check("model_pin_fnmadd_inf", 192'({pin.sign_prod, pin.sign_c_eff, pin.result}),
          192'({1'b1, 1'b0, 32'h7F800000}));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 192'(bus.Valid_SO), 192'(1'b0));
    check("reset_ready", 192'(bus.Ready_SO), 192'(1'b1));
    check("reset_data",  192'(dut_out()), 192'(0));

    send_chk("inf_x_zero",   2'b00, P_INF, 32'h0, 32'h0,   1, QNAN, 1, 24'h000000);
    send_chk("fmsub_inf",    2'b01, P_INF, ONE,   P_INF,   1, QNAN, 1, 24'h800000);
    check("fmsub_sign_prod",  192'(bus.Sign_prod_DO), 192'(1'b0));
    check("fmsub_sign_c_eff", 192'(bus.Sign_c_eff_DO), 192'(1'b1));
    send_chk("fmadd_inf",    2'b00, P_INF, ONE,   P_INF,   1, 32'h7F800000, 0, 24'h800000);
    send_chk("fnmadd_cinf",  2'b11, ONE,   ONE,   N_INF,   1, 32'h7F800000, 0, 24'h800000);
    send_chk("snan_a",       2'b11, 32'h7F800001, ONE, N_INF, 1, QNAN, 1, 24'h800000);
    send_chk("qnan_a",       2'b11, 32'h7FC00001, ONE, N_INF, 1, QNAN, 0, 24'h800000);
    send_chk("normal",       2'b00, ONE,   ONE,   ONE,     0, 32'h0, 0, 24'h800000);
`ifdef FMAC_DEN_FTZ_EN
    send_chk("den_b",        2'b00, P_INF, 32'h00000001, 32'h0, 1, QNAN, 1, 24'h000000);
`else
    send_chk("den_b",        2'b00, P_INF, 32'h00000001, 32'h0, 1, 32'h7F800000, 0, 24'h000001);
`endif

    // Back-to-back stream with a 2-cycle downstream stall.
    @(posedge clk); #1;
    base = n_out;
    bus.Ready_SI = 1'b1;
    drive(2'b00, ONE, ONE, ONE);
    bus.Valid_SI = 1'b1;
    @(posedge clk); #1;               // set 1 into output register
    bus.Ready_SI = 1'b0;
    drive(2'b01, P_INF, ONE, P_INF);
    @(negedge clk);
    check("stream_ready_skid_empty", 192'(bus.Ready_SO), 192'(1'b1));
    @(posedge clk); #1;               // set 2 into skid
    drive(2'b11, ONE, ONE, N_INF);
    @(negedge clk);
    check("stream_ready_drop", 192'(bus.Ready_SO), 192'(1'b0));
    @(posedge clk); #1;               // set 3 refused
    bus.Ready_SI = 1'b1;
    @(negedge clk);
    check("stream_set3_held", 192'(bus.Ready_SO), 192'(1'b0));
    check("stream_head_set1", 192'(bus.Special_SO), 192'(1'b0));
    @(posedge clk); #1;               // set 1 leaves, skid moves up
    @(negedge clk);
    check("stream_ready_back", 192'(bus.Ready_SO), 192'(1'b1));
    check("stream_head_set2",  192'(bus.Special_result_DO), 192'(QNAN));
    @(posedge clk); #1;               // set 3 accepted
    bus.Valid_SI = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stream_count", 192'(n_out - base), 192'(3));

    // Reset while both entries are occupied.
    @(posedge clk); #1;
    bus.Ready_SI = 1'b0;
    drive(2'b00, P_INF, ONE, 32'h0);
    bus.Valid_SI = 1'b1;
    @(posedge clk); #1;
    drive(2'b00, ONE, ONE, P_INF);
    @(posedge clk); #1;
    bus.Valid_SI = 1'b0;
    @(negedge clk);
    check("midrst_full", 192'(bus.Ready_SO), 192'(1'b0));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus.Ready_SI = 1'b1;
    @(negedge clk);
    check("midrst_valid", 192'(bus.Valid_SO), 192'(1'b0));
    check("midrst_ready", 192'(bus.Ready_SO), 192'(1'b1));
    check("midrst_data",  192'(dut_out()), 192'(0));
    send_chk("after_rst", 2'b10, N_INF, ONE, 32'h0, 1, 32'h7F800000, 0, 24'h800000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 192'(q.size()), 192'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/special_case_fmac.md
Name: special_case_fmac

Overview:
- Stage directly downstream of FMAC operand disassembly/classification.
- Consumes unpacked sign/exponent/mantissa fields and class flags for operands a, b, c.
- Resolves IEEE-754 special cases (NaN, Inf, invalid) into an early-out result and flags.
- Registers all fields into the FMAC datapath behind a valid/ready handshake with a 2-entry skid buffer.

Parameters:
- C_OP, 32, operand width.
- C_EXP, 8, exponent width.
- C_MANT, 23, stored mantissa width; mantissa fields carry C_MANT+1 bits including the hidden bit.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  synchronous active-high reset.
- Valid_SI  in  1  upstream operands valid.
- Ready_SO  out  1  stage can accept.
- Op_SI  in  2  00 fmadd (a*b+c), 01 fmsub (a*b-c), 10 fnmsub (-(a*b)+c), 11 fnmadd (-(a*b)-c).
- Sign_{a,b,c}_DI  in  1 each  operand signs.
- Exp_{a,b,c}_DI  in  C_EXP each  exponents; denormals already mapped to 1.
- Mant_{a,b,c}_DI  in  C_MANT+1 each  mantissas including hidden bit.
- Inf_{a,b,c}_SI, NaN_{a,b,c}_SI, DeN_{a,b,c}_SI, Zero_a_SI, Zero_b_SI  in  1 each  class flags.
- Valid_SO  out  1  output valid.
- Ready_SI  in  1  downstream accepts.
- Op_SO, Sign_*_DO, Exp_*_DO, Mant_*_DO, DeN_*_SO, Zero_a_SO, Zero_b_SO  out  same widths  registered copies of the inputs.
- Sign_prod_DO  out  1  effective product sign.
- Sign_c_eff_DO  out  1  effective addend sign.
- Special_SO  out  1  result fully determined here; datapath result is to be discarded.
- Special_result_DO  out  C_OP  early-out result.
- NV_SO  out  1  invalid-operation flag.

Behaviour:
- Reset: Valid_SO=0, Ready_SO=1, skid empty; every data output is 0.
- Effective signs: Sign_prod = Sa^Sb^Op[1]; Sign_c_eff = Sc^Op[0].
- Special-case classification is combinational on the inputs and captured together with the data. Priority, highest first:
  1. Any NaN_x -> Special=1, result 0x7FC00000 (canonical qNaN). NV=1 if any NaN operand has Mant[C_MANT-1]=0 (sNaN).
  2. (Inf_a & Zero_b) | (Zero_a & Inf_b) -> NaN, NV=1.
  3. (Inf_a | Inf_b) & Inf_c & (Sign_prod != Sign_c_eff) -> NaN, NV=1.
  4. Inf_a | Inf_b -> {Sign_prod, all-ones exponent, zero mantissa}, NV=0.
  5. Inf_c -> {Sign_c_eff, all-ones exponent, zero mantissa}, NV=0.
  6. Otherwise Special=0, result 0, NV=0.
- Latency: 1 cycle from accept (Valid_SI & Ready_SO) to Valid_SO.
- Holding rule: output register holds its contents while Valid_SO & ~Ready_SI.
- Accept with output register free or draining (~Valid_SO | Ready_SI), skid empty: load the output register.
- Accept while output is stalled: load the skid register. Ready_SO goes 0 the next cycle (Ready_SO = ~skid_valid, registered).
- Output drains while skid is full: skid moves to the output register; Ready_SO returns to 1 next cycle.
- Transaction order is always preserved.
- Reset asserted mid-transfer: both entries are dropped, no partial state remains, and Valid_SO=0 on the next cycle.
- No combinational path from Ready_SI to Ready_SO.

Optional Feature:
- Macro: FMAC_DEN_FTZ_EN.
- Defined (flush-to-zero): any DeN_x input is treated as zero.
  - Registered Mant_x is forced to 0 and Exp_x to 0.
  - DeN_x_SO is forced to 0.
  - For a and b, Zero_x_SO is set, and the set flag takes part in rule 2 (e.g. Inf_a with denormal b -> NaN, NV=1).
- Undefined: denormal fields and flags pass through unchanged; rule 2 uses only Zero_a_SI/Zero_b_SI.

Test Plan:
- Reset held 3 cycles, then released -> Valid_SO=0, Ready_SO=1, all data outputs 0.
- fmadd, a=+Inf, b=+0 -> one cycle later Special=1, result 0x7FC00000, NV=1.
- fmsub, a=+Inf, b=+1.0, c=+Inf -> Sign_c_eff=1, Sign_prod=0, so NaN, NV=1. Same operands under fmadd -> result 0x7F800000, NV=0.
- fnmadd, c=-Inf, a=b=1.0 -> result 0x7F800000. a=sNaN 0x7F800001 -> 0x7FC00000, NV=1. a=qNaN 0x7FC00001 -> 0x7FC00000, NV=0.
- Back-to-back stream of 3 operand sets with Ready_SI held 0 for 2 cycles:
  - second set lands in skid and Ready_SO drops the following cycle;
  - third set is not accepted until the skid drains;
  - after Ready_SI rises, all 3 emerge in order with no loss or duplication.
- With FMAC_DEN_FTZ_EN: a=+Inf, b=0x00000001 -> NaN, NV=1, Mant_b_DO=0. Without the macro -> 0x7F800000, Mant_b_DO=0x000001.
